lfsr_rr_arbiter: RTL and testbench

Shares a single 5-bit Galois LFSR pseudo-random source among `N_REQ` requesters. A round-robin arbiter picks one requester per cycle and returns the current LFSR word to it with a one-cycle grant pulse. The LFSR advances exactly once per grant. The block also supports run-time reseeding and flags each completed 31-step period. It sits between the LFSR datapath and the consumers, such as test-pattern and noise users, that previously each owned a private LFSR.

---
 rtl/lfsr_pkg.sv | 16 +
 rtl/lfsr5_core.sv | 26 ++
 rtl/lfsr_rr_arbiter.sv | 98 +++++++++
 tb/tb_lfsr_rr_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants and tap function for the 5-bit Galois LFSR.
// Used by the LFSR core and the round-robin sharing arbiter.
package lfsr_pkg;

    localparam int LFSR_W = 5;
    localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 5'b11111;
    localparam int LFSR_PERIOD = 31;

    // Bit order is {n4, n3, n2, n1, n0}.
    function automatic logic [LFSR_W-1:0] lfsr5_next(
        input logic [LFSR_W-1:0] q
    );
        lfsr5_next = {q[3], q[2], q[1] ^ q[4], q[0], q[4]};
    endfunction

endpackage

// File: rtl/lfsr5_core.sv
// 5-bit Galois LFSR state register.
// A load takes priority over a step; reset returns to SEED.
module lfsr5_core
    import lfsr_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic              load,
    input  logic [LFSR_W-1:0] value,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= SEED;
        end else if (load) begin
            q <= value;
        end else if (step) begin
            q <= lfsr5_next(q);
        end
    end

endmodule

// File: rtl/lfsr_rr_arbiter.sv
// Round-robin arbiter sharing one 5-bit LFSR among N_REQ requesters.
// Each grant returns the current LFSR word and advances it once.
module lfsr_rr_arbiter
    import lfsr_pkg::*;
#(
    parameter int                N_REQ = 4,
    parameter logic [LFSR_W-1:0] SEED  = LFSR_DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_val,
    output logic [N_REQ-1:0]  gnt,
    output logic              rnd_valid,
    output logic [LFSR_W-1:0] rnd,
    output logic              period_wrap
);

    localparam int PW = $clog2(N_REQ);
    localparam logic [PW-1:0] LAST = PW'(N_REQ - 1);
    localparam logic [LFSR_W-1:0] CNT_LAST = LFSR_W'(LFSR_PERIOD - 1);
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    logic [PW-1:0]     rr_ptr;
    logic [LFSR_W-1:0] step_cnt;
    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] load_val;
    logic [N_REQ-1:0]  eff;
    logic [PW-1:0]     idx;
    logic [PW-1:0]     win;
    logic              hit;
    logic              do_grant;
    logic [PW-1:0]     ptr_next;

    // Masking the live grant lets a requester drop req one cycle late.
    always_comb begin
        eff = req & ~gnt;
        hit = 1'b0;
        win = '0;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = PW'((int'(rr_ptr) + i) % N_REQ);
            if (!hit && ((eff >> idx) & ONE) != '0) begin
                hit = 1'b1;
                win = idx;
            end
        end
    end

    assign do_grant = hit && !seed_load;
    assign ptr_next = (win == LAST) ? '0 : win + 1'b1;
    assign load_val = (seed_val == '0) ? SEED : seed_val;

    lfsr5_core #(
        .SEED (SEED)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .step  (do_grant),
        .load  (seed_load),
        .value (load_val),
        .q     (lfsr_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (do_grant) begin
            rr_ptr <= ptr_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt <= '0;
        end else if (seed_load) begin
            step_cnt <= '0;
        end else if (do_grant) begin
            step_cnt <= (step_cnt == CNT_LAST) ? '0 : step_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt         <= '0;
            rnd         <= '0;
            rnd_valid   <= 1'b0;
            period_wrap <= 1'b0;
        end else begin
            gnt         <= do_grant ? (ONE << win) : '0;
            rnd         <= do_grant ? lfsr_q : '0;
            rnd_valid   <= do_grant;
            period_wrap <= do_grant && (step_cnt == CNT_LAST);
        end
    end

endmodule

// File: tb/tb_lfsr_rr_arbiter.sv
// Bench for lfsr_rr_arbiter: directed scenarios plus random traffic
// compared against a sequence-position model of the shared LFSR.
module tb_lfsr_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       seed_load;
    logic [4:0] seed_val;
    logic [3:0] gnt;
    logic       rnd_valid;
    logic [4:0] rnd;
    logic       period_wrap;

    int checks = 0;
    int errors = 0;

    logic [4:0] cyc [31];
    int         m_pos, m_ptr, m_cnt;
    logic [3:0] m_gnt;
    logic [3:0] e_gnt;
    logic [4:0] e_rnd;
    logic       e_valid, e_wrap;

    lfsr_rr_arbiter #(
        .N_REQ (4),
        .SEED  (5'h1F)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .seed_load   (seed_load),
        .seed_val    (seed_val),
        .gnt         (gnt),
        .rnd_valid   (rnd_valid),
        .rnd         (rnd),
        .period_wrap (period_wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] tap(input logic [4:0] q);
        return {q[3], q[2], q[1] ^ q[4], q[0], q[4]};
    endfunction

    function automatic int find_pos(input logic [4:0] v);
        for (int i = 0; i < 31; i++)
            if (cyc[i] == v) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_pos = 0;
        m_ptr = 0;
        m_cnt = 0;
        m_gnt = 4'b0;
    endtask

    // Advance the model one cycle from the current inputs, then clock.
    task automatic tick();
        logic [3:0] eff;
        int w;
        eff = req & ~m_gnt;
        w = -1;
        e_gnt = 4'b0;
        e_rnd = 5'b0;
        e_valid = 1'b0;
        e_wrap = 1'b0;
        if (seed_load) begin
            m_pos = find_pos(seed_val == 5'b0 ? 5'h1F : seed_val);
            m_cnt = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                int k;
                k = (m_ptr + i) % 4;
                if (w < 0 && ((eff >> k) & 4'b1) != 4'b0) w = k;
            end
            if (w >= 0) begin
                e_gnt = 4'b1 << w;
                e_rnd = cyc[m_pos];
                e_valid = 1'b1;
                e_wrap = (m_cnt == 30);
                m_pos = (m_pos + 1) % 31;
                m_cnt = (m_cnt + 1) % 31;
                m_ptr = (w + 1) % 4;
            end
        end
        m_gnt = e_gnt;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b0;
        seed_load = 1'b0;
        seed_val = 5'b0;
        #3;
        checks++;
        if ({gnt, rnd, rnd_valid, period_wrap} !== 11'b0) begin
            errors++;
            $display("FAIL reset_values: got gnt=%b rnd=%h v=%b w=%b, want 0",
                     gnt, rnd, rnd_valid, period_wrap);
        end
        #4 rst = 1'b0;
        model_reset();
        tick();
        checks++;
        if ({gnt, rnd, rnd_valid, period_wrap} !== 11'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got gnt=%b rnd=%h, want 0",
                     gnt, rnd);
        end
    endtask

    task automatic test_single();
        logic [4:0] want [3];
        int g;
        want[0] = 5'h1F;
        want[1] = 5'h1B;
        want[2] = 5'h13;
        g = 0;
        req = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ((i % 2 == 0) && (gnt !== 4'b0001 || rnd !== want[g])) begin
                errors++;
                $display("FAIL single_grant%0d: got gnt=%b rnd=%h, want 0001 %h",
                         i, gnt, rnd, want[g]);
            end else if ((i % 2 == 1) && (gnt !== 4'b0 || rnd_valid !== 1'b0)) begin
                errors++;
                $display("FAIL single_gap%0d: got gnt=%b v=%b, want 0 0",
                         i, gnt, rnd_valid);
            end
            if (i % 2 == 0) g++;
        end
    endtask

    task automatic test_round_robin();
        int prev;
        prev = -1;
        req = 4'b1111;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if ({gnt, rnd, rnd_valid, period_wrap} !==
                {e_gnt, e_rnd, e_valid, e_wrap} || $countones(gnt) > 1) begin
                errors++;
                $display("FAIL rr_model%0d: got gnt=%b rnd=%h v=%b w=%b, want %b %h %b %b",
                         i, gnt, rnd, rnd_valid, period_wrap,
                         e_gnt, e_rnd, e_valid, e_wrap);
            end
            if (prev >= 0) begin
                checks++;
                if (gnt !== (4'b1 << ((prev + 1) % 4))) begin
                    errors++;
                    $display("FAIL rr_order%0d: got gnt=%b, want index %0d",
                             i, gnt, (prev + 1) % 4);
                end
            end
            for (int k = 0; k < 4; k++)
                if (gnt[k]) prev = k;
        end
        req = 4'b0;
        tick();
    endtask

    task automatic test_reseed_zero();
        req = 4'b0010;
        seed_load = 1'b1;
        seed_val = 5'h00;
        tick();
        seed_load = 1'b0;
        checks++;
        if (gnt !== 4'b0 || rnd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reseed_no_grant: got gnt=%b v=%b, want 0 0",
                     gnt, rnd_valid);
        end
        tick();
        checks++;
        if (gnt !== 4'b0010 || rnd !== 5'h1F) begin
            errors++;
            $display("FAIL reseed_zero_rnd: got gnt=%b rnd=%h, want 0010 1f",
                     gnt, rnd);
        end
        req = 4'b0;
        tick();
    endtask

    task automatic test_period();
        int wraps;
        wraps = 0;
        req = 4'b0;
        seed_load = 1'b1;
        seed_val = 5'h05;
        tick();
        seed_load = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 31; i++) begin
            tick();
            checks++;
            if (rnd_valid !== 1'b1 || rnd === 5'h00 ||
                period_wrap !== (i == 30) || rnd !== e_rnd) begin
                errors++;
                $display("FAIL period_step%0d: got v=%b rnd=%h w=%b, want 1 %h %b",
                         i, rnd_valid, rnd, period_wrap, e_rnd, i == 30);
            end
            if (period_wrap) wraps++;
        end
        tick();
        checks++;
        if (rnd !== 5'h05 || period_wrap !== 1'b0 || wraps != 1) begin
            errors++;
            $display("FAIL period_return: got rnd=%h w=%b wraps=%0d, want 05 0 1",
                     rnd, period_wrap, wraps);
        end
    endtask

    task automatic test_async_reset();
        req = 4'b1111;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({gnt, rnd, rnd_valid, period_wrap} !== 11'b0) begin
            errors++;
            $display("FAIL async_reset: got gnt=%b rnd=%h v=%b w=%b, want 0",
                     gnt, rnd, rnd_valid, period_wrap);
        end
        #2 rst = 1'b0;
        model_reset();
        tick();
        checks++;
        if (gnt !== 4'b0001 || rnd !== 5'h1F) begin
            errors++;
            $display("FAIL post_reset_grant: got gnt=%b rnd=%h, want 0001 1f",
                     gnt, rnd);
        end
    endtask

    task automatic test_drop();
        int n2;
        n2 = 0;
        req = 4'b0;
        tick();
        req = 4'b0100;
        tick();
        if (gnt[2]) n2++;
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL drop_first: got gnt=%b, want 0100", gnt);
        end
        req = 4'b1000;
        tick();
        if (gnt[2]) n2++;
        checks++;
        if (gnt !== 4'b1000) begin
            errors++;
            $display("FAIL drop_next: got gnt=%b, want 1000", gnt);
        end
        req = 4'b0;
        tick();
        if (gnt[2]) n2++;
        tick();
        if (gnt[2]) n2++;
        checks++;
        if (n2 != 1) begin
            errors++;
            $display("FAIL drop_count: got %0d grants to 2, want 1", n2);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            req = 4'($urandom_range(0, 15));
            seed_load = ($urandom_range(0, 9) == 0);
            seed_val = 5'($urandom_range(0, 31));
            tick();
            checks++;
            if ({gnt, rnd, rnd_valid, period_wrap} !==
                {e_gnt, e_rnd, e_valid, e_wrap} || $countones(gnt) > 1) begin
                errors++;
                $display("FAIL random%0d: got gnt=%b rnd=%h v=%b w=%b, want %b %h %b %b",
                         i, gnt, rnd, rnd_valid, period_wrap,
                         e_gnt, e_rnd, e_valid, e_wrap);
            end
        end
        seed_load = 1'b0;
        req = 4'b0;
    endtask

    initial begin
        cyc[0] = 5'h1F;
        for (int i = 1; i < 31; i++)
            cyc[i] = tap(cyc[i-1]);
        test_reset();
        test_single();
        test_round_robin();
        test_reseed_zero();
        test_period();
        test_async_reset();
        test_drop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
